// File: rtl/sample_frame_tx_pkg.sv
// Shared types and constants for the sample frame transmitter.
package sample_frame_tx_pkg;

  localparam int FRAME_BYTES = 4;
  localparam int PAD_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    ARM,
    WAIT
  } state_t;

  // Select one byte of a frame, byte 0 being the most significant.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BYTES*8-1:0] frame,
                                            input logic [1:0]               idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = frame[31:24];
      2'd1:    b = frame[23:16];
      2'd2:    b = frame[15:8];
      default: b = frame[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sample_frame_tx_fifo.sv
// Synchronous single-clock FIFO holding {dac, adc} pairs, with occupancy flags.
module sample_fifo #(
  parameter int DW2 = 24,
  parameter int AW  = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr,
  input  logic [DW2-1:0] wdata,
  input  logic           rd,
  output logic [DW2-1:0] rdata,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);

  localparam int DEPTH = 2**AW;

  logic [DW2-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_rd;
  logic           do_wr;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign do_rd = rd && (cnt != '0);
  assign do_wr = wr && (!full || do_rd);

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // Storage write.
  // NOTE: the array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at 2**AW.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sample_frame_tx.sv
// Captures {dac, adc} sample pairs, buffers them and sends each as a 4-byte UART frame.
module sample_frame_tx
  import sample_frame_tx_pkg::*;
#(
  parameter int DW = 12,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [DW-1:0] dac_i,
  input  logic [DW-1:0] adc_i,
  input  logic          clr_i,
  input  logic          tx_busy_i,
  output logic [7:0]    txd_o,
  output logic          txstart_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o
);

  state_t              state_q;
  state_t              state_d;
  logic [2*DW-1:0]     head;
  logic [PAD_W*2-1:0]  head_frame;
  logic [PAD_W*2-1:0]  frame_q;
  logic [1:0]          idx_q;
  logic [7:0]          txd_q;
  logic [7:0]          cur_byte;
  logic                pop;
  logic                txstart;
  logic                idx_inc;
  logic                ovf_q;

  sample_fifo #(
    .DW2 (2*DW),
    .AW  (AW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wr    (wr_i),
    .wdata ({dac_i, adc_i}),
    .rd    (pop),
    .rdata (head),
    .full  (full_o),
    .empty (empty_o),
    .count (count_o)
  );

  // Each code is zero-extended to 16 bits so the frame layout is independent of DW.
  assign head_frame = {PAD_W'(head[2*DW-1:DW]), PAD_W'(head[DW-1:0])};
  assign cur_byte   = frame_byte(frame_q, idx_q);

  // txd holds the last sent byte between pulses and shows the new byte during the pulse itself.
  assign txstart_o = txstart;
  assign txd_o     = txstart ? cur_byte : txd_q;
  assign ovf_o     = ovf_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    txstart = 1'b0;
    idx_inc = 1'b0;
    case (state_q)
      IDLE: if (!empty_o) state_d = LOAD;
      LOAD: begin
        pop     = 1'b1;
        state_d = SEND;
      end
      SEND: if (!tx_busy_i) begin
        txstart = 1'b1;
        state_d = ARM;
      end
      // The UART raises busy one cycle after the pulse, so busy is not trusted here.
      ARM:  state_d = WAIT;
      WAIT: if (!tx_busy_i) begin
        if (idx_q != 2'(FRAME_BYTES-1)) begin
          idx_inc = 1'b1;
          state_d = SEND;
        end else if (!empty_o) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame register, byte index and last-sent byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      idx_q   <= '0;
      txd_q   <= '0;
    end else begin
      if (pop) begin
        frame_q <= head_frame;
        idx_q   <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 1'b1;
      end
      if (txstart) txd_q <= cur_byte;
    end
  end

  // Sticky overflow: a write dropped because the FIFO was full and nothing was popped.
  // Setting takes priority over clearing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        ovf_q <= 1'b0;
    else if (wr_i && full_o && !pop)  ovf_q <= 1'b1;
    else if (clr_i)                   ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_sample_frame_tx.sv
// Self-checking bench for sample_frame_tx: table vectors, UART model and byte scoreboard.
module tb_sample_frame_tx;
  import sample_frame_tx_pkg::*;

  localparam int DW       = 12;
  localparam int AW       = 4;
  localparam int BUSY_CYC = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic          clr;
  logic [DW-1:0] dac;
  logic [DW-1:0] adc;
  logic          hold_busy;
  logic          uart_busy;
  logic          tx_busy;
  logic [7:0]    txd;
  logic          txstart;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;

  int         total     = 0;
  int         bad       = 0;
  int         pulse_cnt = 0;
  int         extra     = 0;
  logic       prev_start = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] dac;
    logic [DW-1:0] adc;
    logic [31:0]   frame;
  } vec_t;

  vec_t vecs[4];

  assign tx_busy = hold_busy | uart_busy;

  sample_frame_tx #(.DW(DW), .AW(AW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_i      (wr),
    .dac_i     (dac),
    .adc_i     (adc),
    .clr_i     (clr),
    .tx_busy_i (tx_busy),
    .txd_o     (txd),
    .txstart_o (txstart),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count),
    .ovf_o     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_frame(input logic [DW-1:0] d, input logic [DW-1:0] a);
    return {4'h0, d, 4'h0, a};
  endfunction

  task automatic push_frame(input logic [31:0] f);
    exp_q.push_back(f[31:24]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[7:0]);
  endtask

  // One-cycle write; returns at the falling edge just after the write edge.
  task automatic drive_write(input logic [DW-1:0] d, input logic [DW-1:0] a);
    @(negedge clk);
    wr = 1'b1; dac = d; adc = a;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_state(input string name, input state_t st, input int want_idx, input int budget);
    int n = 0;
    while (!(dut.state_q == st && (want_idx < 0 || int'(dut.idx_q) == want_idx)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Waits until the scoreboard is empty and the link has been quiet for a few cycles.
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && empty && !tx_busy) quiet++;
      else quiet = 0;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic write_burst(input int n);
    logic [DW-1:0] d;
    logic [DW-1:0] a;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      a = DW'($urandom);
      @(negedge clk);
      wr = 1'b1; dac = d; adc = a;
      push_frame(exp_frame(d, a));
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  // UART model: consumes each start pulse, scores the byte, then stays busy for a while.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (txstart === 1'b1) begin
        pulse_cnt++;
        if (exp_q.size() != 0) check("tx_byte", 32'(txd), 32'(exp_q.pop_front()));
        else extra++;
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Start pulses must never be back to back.
  always @(negedge clk) begin
    if (txstart === 1'b1) check("no_back_to_back", 32'(prev_start), 32'd0);
    prev_start = txstart;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    vecs[0] = '{dac: 12'hABC, adc: 12'h123, frame: 32'h0ABC_0123};
    vecs[1] = '{dac: 12'h000, adc: 12'hFFF, frame: 32'h0000_0FFF};
    vecs[2] = '{dac: 12'hFFF, adc: 12'h000, frame: 32'h0FFF_0000};
    vecs[3] = '{dac: 12'h801, adc: 12'h7FE, frame: 32'h0801_07FE};

    rst = 1'b1; wr = 1'b0; clr = 1'b0; hold_busy = 1'b0; dac = '0; adc = '0;
    repeat (3) @(negedge clk);
    check("rst_count",   32'(count),   32'd0);
    check("rst_empty",   32'(empty),   32'd1);
    check("rst_full",    32'(full),    32'd0);
    check("rst_ovf",     32'(ovf),     32'd0);
    check("rst_txstart", 32'(txstart), 32'd0);
    check("rst_txd",     32'(txd),     32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames from the table, with latency checks.
    for (int v = 0; v < 4; v++) begin
      push_frame(vecs[v].frame);
      drive_write(vecs[v].dac, vecs[v].adc);
      check("lat_empty_n",    32'(empty),   32'd0);
      check("lat_start_n",    32'(txstart), 32'd0);
      @(negedge clk);
      check("lat_start_n1",   32'(txstart), 32'd0);
      @(negedge clk);
      check("lat_start_n2",   32'(txstart), 32'd1);
      check("lat_txd_n2",     32'(txd),     32'(vecs[v].frame[31:24]));
      check("lat_empty_load", 32'(empty),   32'd1);
      wait_drain("drain_vec", 500);
    end

    // Fill while the link is stalled; overflow, set-wins and clear.
    @(posedge clk); #1 hold_busy = 1'b1;
    push_frame(exp_frame(12'h5A5, 12'hA5A));
    drive_write(12'h5A5, 12'hA5A);
    wait_state("reach_send_fill", SEND, -1, 20);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr = 1'b1; dac = DW'(12'h100 + i); adc = DW'(i * 3);
      push_frame(exp_frame(DW'(12'h100 + i), DW'(i * 3)));
    end
    @(negedge clk);
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf",   32'(ovf),   32'd0);
    dac = 12'hDEA; adc = 12'hD00;
    @(negedge clk);
    wr = 1'b0;
    check("ovf_set",       32'(ovf),   32'd1);
    check("ovf_count",     32'(count), 32'd16);
    wr = 1'b1; clr = 1'b1; dac = 12'hBAD; adc = 12'hBAD;
    @(negedge clk);
    wr = 1'b0; clr = 1'b0;
    check("ovf_set_wins",  32'(ovf),   32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovf_cleared",   32'(ovf),   32'd0);

    // Write while full in the same cycle as the LOAD pop.
    @(posedge clk); #1 hold_busy = 1'b0;
    wait_state("reach_load_full", LOAD, -1, 200);
    check("pre_pop_count", 32'(count), 32'd16);
    wr = 1'b1; dac = 12'h3C3; adc = 12'hC3C;
    push_frame(exp_frame(12'h3C3, 12'hC3C));
    @(negedge clk);
    wr = 1'b0;
    check("pop_wr_count", 32'(count), 32'd16);
    check("pop_wr_full",  32'(full),  32'd1);
    check("pop_wr_ovf",   32'(ovf),   32'd0);
    wait_drain("drain_full", 3000);

    // Busy stuck high for 50 cycles in SEND.
    @(posedge clk); #1 hold_busy = 1'b1;
    push_frame(exp_frame(12'h777, 12'h888));
    drive_write(12'h777, 12'h888);
    wait_state("reach_send_stall", SEND, -1, 20);
    p0 = pulse_cnt;
    repeat (50) @(negedge clk);
    check("stall_no_pulse", 32'(pulse_cnt), 32'(p0));
    @(posedge clk); #1 hold_busy = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_one_pulse", 32'(pulse_cnt), 32'(p0 + 1));
    wait_drain("drain_stall", 500);

    // Asynchronous reset in WAIT of byte 2 with three entries queued.
    @(posedge clk); #1 hold_busy = 1'b1;
    push_frame(exp_frame(12'h111, 12'h222));
    drive_write(12'h111, 12'h222);
    wait_state("reach_send_rst", SEND, -1, 20);
    drive_write(12'h333, 12'h444);
    drive_write(12'h555, 12'h666);
    drive_write(12'h999, 12'hAAA);
    @(posedge clk); #1 hold_busy = 1'b0;
    wait_state("reach_wait_b2", WAIT, 2, 200);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txstart", 32'(txstart), 32'd0);
    check("mid_rst_count",   32'(count),   32'd0);
    check("mid_rst_empty",   32'(empty),   32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (BUSY_CYC + 2) @(negedge clk);
    push_frame(exp_frame(12'hCAF, 12'hE01));
    drive_write(12'hCAF, 12'hE01);
    wait_drain("drain_after_rst", 500);

    // Forty writes in bursts, wrapping the pointers more than twice.
    for (int b = 0; b < 5; b++) begin
      write_burst(8);
      wait_drain("drain_wrap", 1500);
    end

    check("extra_bytes",   32'(extra),        32'd0);
    check("sb_leftover",   32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
